// File: rtl/regfile_16x32b_4rd_2wr.sv
// 16-entry x 32-bit register file with four combinational read ports and
// two synchronous write ports. Write port 1 wins on an address collision.
// No write-to-read bypass: reads always reflect the currently stored value.
module regfile_16x32b_4rd_2wr (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rdport1_ctrl_add,
    output logic [31:0] rdport1_data_out,
    input  logic [3:0]  rdport2_ctrl_add,
    output logic [31:0] rdport2_data_out,
    input  logic [3:0]  rdport3_ctrl_add,
    output logic [31:0] rdport3_data_out,
    input  logic [3:0]  rdport4_ctrl_add,
    output logic [31:0] rdport4_data_out,
    input  logic [3:0]  wrport1_ctrl_add,
    input  logic [31:0] wrport1_data_in,
    input  logic        wrport1_wren,
    input  logic [3:0]  wrport2_ctrl_add,
    input  logic [31:0] wrport2_data_in,
    input  logic        wrport2_wren
);

    localparam int unsigned NumRegs = 16;

    logic [31:0] regs_q [NumRegs];
    logic [31:0] regs_d [NumRegs];

    // Next-state: port 2 applied first so port 1 overrides it on a collision.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wrport2_wren) begin
            regs_d[wrport2_ctrl_add] = wrport2_data_in;
        end
        if (wrport1_wren) begin
            regs_d[wrport1_ctrl_add] = wrport1_data_in;
        end
    end

    // Storage update; reset clears every entry and overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports are pure muxes on stored state (old value until the edge).
    always_comb begin
        rdport1_data_out = regs_q[rdport1_ctrl_add];
        rdport2_data_out = regs_q[rdport2_ctrl_add];
        rdport3_data_out = regs_q[rdport3_ctrl_add];
        rdport4_data_out = regs_q[rdport4_ctrl_add];
    end

endmodule

// File: tb/tb_regfile_16x32b_4rd_2wr.sv
// Self-checking bench for regfile_16x32b_4rd_2wr. Expected read values are
// pushed to a scoreboard queue when read addresses are driven and popped
// when the combinational outputs are sampled.
module tb_regfile_16x32b_4rd_2wr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1, ra2, ra3, ra4;
    logic [31:0] rd1, rd2, rd3, rd4;
    logic [3:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic        we1, we2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mdl [16];

    always #5 clk = ~clk;

    regfile_16x32b_4rd_2wr dut (
        .clk              (clk),
        .rst              (rst),
        .rdport1_ctrl_add (ra1),
        .rdport1_data_out (rd1),
        .rdport2_ctrl_add (ra2),
        .rdport2_data_out (rd2),
        .rdport3_ctrl_add (ra3),
        .rdport3_data_out (rd3),
        .rdport4_ctrl_add (ra4),
        .rdport4_data_out (rd4),
        .wrport1_ctrl_add (wa1),
        .wrport1_data_in  (wd1),
        .wrport1_wren     (we1),
        .wrport2_ctrl_add (wa2),
        .wrport2_data_in  (wd2),
        .wrport2_wren     (we2)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    task automatic do_write(input logic [3:0] a1, input logic [31:0] d1, input logic e1,
                            input logic [3:0] a2, input logic [31:0] d2, input logic e2);
        wa1 = a1; wd1 = d1; we1 = e1;
        wa2 = a2; wd2 = d2; we2 = e2;
        tick();
        if (e2) mdl[a2] = d2;
        if (e1) mdl[a1] = d1;
        we1 = 1'b0;
        we2 = 1'b0;
    endtask

    // Drive four read addresses, queue their expectations, then compare.
    task automatic read4(input string tag,
                         input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] a3, input logic [3:0] a4,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] e;
        ra1 = a1; ra2 = a2; ra3 = a3; ra4 = a4;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        exp_q.push_back(e4);
        #1;
        e = exp_q.pop_front(); check_val($sformatf("%s p1 @%0d", tag, a1), rd1, e);
        e = exp_q.pop_front(); check_val($sformatf("%s p2 @%0d", tag, a2), rd2, e);
        e = exp_q.pop_front(); check_val($sformatf("%s p3 @%0d", tag, a3), rd3, e);
        e = exp_q.pop_front(); check_val($sformatf("%s p4 @%0d", tag, a4), rd4, e);
    endtask

    initial begin
        logic [3:0]  a1, a2, a3, a4;
        logic [31:0] d1, d2;
        logic        e1, e2;

        rst = 1'b1;
        ra1 = '0; ra2 = '0; ra3 = '0; ra4 = '0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
        we1 = 1'b0; we2 = 1'b0;

        // Reset: all registers read as zero on every port.
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            read4("reset", 4'(i), 4'(i), 4'(i), 4'(i), 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // Dual write fill: R[i] = 16*(i+1) and R[i+8] = 16*(i+9) in one cycle each.
        for (int i = 0; i < 8; i++) begin
            do_write(4'(i), 32'(16 * (i + 1)), 1'b1, 4'(i + 8), 32'(16 * (i + 9)), 1'b1);
        end

        // Quad read-back.
        for (int i = 0; i < 4; i++) begin
            read4("readback", 4'(i), 4'(i + 4), 4'(i + 8), 4'(i + 12),
                  32'(16 * (i + 1)), 32'(16 * (i + 5)), 32'(16 * (i + 9)),
                  32'(16 * (i + 13)));
        end

        // Write collision: port 1 wins.
        do_write(4'd10, 32'd100, 1'b1, 4'd10, 32'd1000, 1'b1);
        read4("collision", 4'd10, 4'd10, 4'd10, 4'd10, 32'd100, 32'd100, 32'd100, 32'd100);

        // Enable gating: no write when both enables are low.
        do_write(4'd3, 32'hDEADBEEF, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);
        read4("gating", 4'd3, 4'd3, 4'd3, 4'd3, 32'd64, 32'd64, 32'd64, 32'd64);

        // Read-during-write: old value before the edge, new value after it.
        wa2 = 4'd5; wd2 = 32'h55; we2 = 1'b1;
        read4("rdw before", 4'd5, 4'd5, 4'd5, 4'd5, 32'd96, 32'd96, 32'd96, 32'd96);
        tick();
        we2 = 1'b0;
        mdl[5] = 32'h55;
        read4("rdw after", 4'd5, 4'd5, 4'd5, 4'd5, 32'h55, 32'h55, 32'h55, 32'h55);

        // Reset beats a simultaneous write.
        wa1 = 4'd5; wd1 = 32'h1234; we1 = 1'b1;
        do_reset(1);
        we1 = 1'b0;
        read4("rst after", 4'd5, 4'd0, 4'd10, 4'd15, 32'd0, 32'd0, 32'd0, 32'd0);

        // Random traffic against a reference model, with frequent collisions.
        for (int n = 0; n < 40; n++) begin
            a1 = 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
            d1 = $urandom;
            d2 = $urandom;
            e1 = 1'($urandom_range(0, 1));
            e2 = 1'($urandom_range(0, 1));
            do_write(a1, d1, e1, a2, d2, e2);
            a1 = 4'($urandom_range(0, 15));
            a2 = 4'($urandom_range(0, 15));
            a3 = 4'($urandom_range(0, 15));
            a4 = 4'($urandom_range(0, 15));
            read4("random", a1, a2, a3, a4, mdl[a1], mdl[a2], mdl[a3], mdl[a4]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
